// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM encoding, address-split width helpers and the boot vector.
package icache_dm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } icache_state_t;

    // Boot vector, also used by the fetch stage.
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    function automatic int off_w(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int line_words, input int num_lines);
        return 32 - idx_w(num_lines) - off_w(line_words);
    endfunction

endpackage

// File: rtl/icache_store.sv
// Tag/valid/data arrays: one combinational read port, one word write
// port, tag write with optional valid set, and a flash clear of valids.
module icache_store
    import icache_dm_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64,
    localparam int OFF_W = off_w(LINE_WORDS),
    localparam int IDX_W = idx_w(NUM_LINES),
    localparam int TAG_W = tag_w(LINE_WORDS, NUM_LINES),
    localparam int WO_W  = OFF_W - 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [WO_W-1:0]  rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [WO_W-1:0]  wr_offset,
    input  logic [31:0]      wr_data,
    input  logic             line_done,
    input  logic             line_valid,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             flush
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

    // Valid bits: cleared by reset or flush, set when a live line completes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (line_done && line_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Data and tag arrays carry no reset; valid bits guard their contents.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
        if (line_done) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: zero-latency hits,
// stall-and-refill on miss over a request/grant/beat read bus.
module icache_dm
    import icache_dm_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_address_fIF,
    output logic [31:0] Instr1_2IF,
    output logic        Stall_2IF,
    input  logic        Invalidate,
    output logic        Mem_req,
    output logic [31:0] Mem_addr,
    input  logic        Mem_gnt,
    input  logic        Mem_valid,
    input  logic [31:0] Mem_data
);

    localparam int OFF_W  = off_w(LINE_WORDS);
    localparam int IDX_W  = idx_w(NUM_LINES);
    localparam int TAG_W  = tag_w(LINE_WORDS, NUM_LINES);
    localparam int WO_W   = OFF_W - 2;
    localparam int LINE_W = 32 - OFF_W;
    localparam logic [WO_W-1:0] LAST_BEAT = WO_W'(LINE_WORDS - 1);

    icache_state_t     state;
    logic [LINE_W-1:0] miss_line;
    logic [WO_W-1:0]   beat;
    logic              kill;

    logic [WO_W-1:0]   offset;
    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              hit;
    logic              wr_en;
    logic              line_done;
    logic              unused_bits;

    assign offset      = Instr_address_fIF[OFF_W-1:2];
    assign index       = Instr_address_fIF[OFF_W+IDX_W-1:OFF_W];
    assign tag         = Instr_address_fIF[31:OFF_W+IDX_W];
    assign unused_bits = ^Instr_address_fIF[1:0];

    assign hit = RESET && (state == S_IDLE) && rd_valid && (rd_tag == tag);

    assign Instr1_2IF = hit ? rd_data : 32'h0;
    assign Stall_2IF  = !hit || Invalidate;
    assign Mem_addr   = {miss_line, {OFF_W{1'b0}}};

    assign wr_en     = (state == S_FILL) && Mem_valid;
    assign line_done = wr_en && (beat == LAST_BEAT);

    icache_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_store (
        .CLK        (CLK),
        .RESET      (RESET),
        .rd_index   (index),
        .rd_offset  (offset),
        .rd_valid   (rd_valid),
        .rd_tag     (rd_tag),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_index   (miss_line[IDX_W-1:0]),
        .wr_offset  (beat),
        .wr_data    (Mem_data),
        .line_done  (line_done),
        .line_valid (!kill && !Invalidate),
        .wr_tag     (miss_line[LINE_W-1:IDX_W]),
        .flush      (Invalidate)
    );

    // Miss FSM: latch the missing line, request it, then count in the beats.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_IDLE;
            miss_line <= '0;
            beat      <= '0;
            kill      <= 1'b0;
            Mem_req   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (!Invalidate && !hit) begin
                        miss_line <= Instr_address_fIF[31:OFF_W];
                        Mem_req   <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (Invalidate) kill <= 1'b1;
                    if (Mem_gnt) begin
                        Mem_req <= 1'b0;
                        beat    <= '0;
                        state   <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (Invalidate) kill <= 1'b1;
                    if (Mem_valid) begin
                        beat <= beat + WO_W'(1);
                        if (beat == LAST_BEAT) begin
                            kill  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    Mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Instruction-side memory responder for the fetch stage.
- The fetch stage presents a word address each cycle; on a hit this block returns the instruction in the same cycle.
- On a miss it holds the fetch stage via Stall_2IF and refills a line from main memory over a request/grant/beat read bus.
- Direct-mapped, read-only; sits between the fetch stage and the main memory arbiter.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).
- NUM_LINES, 64, number of lines (power of 2).
- Derived: OFF_W = log2(LINE_WORDS) + 2; IDX_W = log2(NUM_LINES); TAG_W = 32 - IDX_W - OFF_W.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- Instr_address_fIF  in  32  fetch address from the fetch stage; bits [1:0] ignored.
- Instr1_2IF  out  32  instruction at Instr_address_fIF; valid when Stall_2IF=0.
- Stall_2IF  out  1  fetch stage must freeze.
- Invalidate  in  1  one-cycle pulse: clear all valid bits.
- Mem_req  out  1  line read request.
- Mem_addr  out  32  line-aligned request address.
- Mem_gnt  in  1  request accepted (sampled in REQ only).
- Mem_valid  in  1  beat valid (sampled in FILL only).
- Mem_data  in  32  beat data.

Behaviour:
- Address split: offset = addr[OFF_W-1:2], index = addr[OFF_W+IDX_W-1:OFF_W], tag = addr[31:OFF_W+IDX_W].
- hit = valid[index] & (tag_store[index] == tag), evaluated combinationally in IDLE only.
- Instr1_2IF = data[index][offset] when hit, else 32'h0 (a bubble/NOP). Combinational, zero latency.
- Stall_2IF = (state != IDLE) | !hit.
- States:
  - IDLE: on miss (and no Invalidate this cycle), latch miss_addr <= Instr_address_fIF and go to REQ.
  - REQ: Mem_req=1, Mem_addr = {miss_addr[31:OFF_W], 0}. On Mem_gnt go to FILL with beat counter = 0.
  - FILL: Mem_req=0. Each Mem_valid beat writes data[miss_index][beat] and increments the counter.
    - On beat LINE_WORDS-1: write tag, set valid (unless the line was killed), go to IDLE.
- Beats arrive in ascending word order; no critical-word-first.
- Mem_gnt and Mem_valid are ignored outside their respective states.
- Miss penalty with immediate grant and back-to-back beats: Stall_2IF high for LINE_WORDS+2 cycles, counted from the miss cycle.
- Address change during REQ/FILL (branch redirect): the fill completes for the latched miss_addr; the new address is looked up on return to IDLE.
- Invalidate:
  - In IDLE: clears all valid bits at the edge. Stall_2IF is forced to 1 that cycle and no miss is launched.
  - In REQ/FILL: clears all valid bits and sets a kill flag. The bus transaction runs to completion, but the filled line is not marked valid. The kill flag clears on entry to IDLE.
- Reset, including mid-fill:
  - State IDLE, all valid bits 0, kill 0, counter 0, Mem_req 0, Mem_addr 0.
  - Stall_2IF=1 and Instr1_2IF=0 while RESET=0.
  - Any in-flight memory transaction is abandoned; the memory side is reset by the same RESET.
- Data/tag arrays are not reset.
- Tag/data write and valid set occur on the same edge; a hit is visible the next cycle.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, REQ, FILL).
  - Derived width functions (OFF_W, IDX_W, TAG_W).
  - Reset vector constant 32'hBFC00000, shared with the fetch stage.
- Sub-module icache_store: tag/valid/data arrays with one combinational read port, one word write port, line-valid set, and flash-clear. Top level holds the FSM, counter and kill flag.

Test Plan:
- Cold miss: after reset, address 0xBFC00000; memory grants immediately and returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 back-to-back -> Stall_2IF high 6 cycles; Mem_addr=0xBFC00000; then Instr1_2IF=0x11111111 with stall 0.
- Hits: addresses 0xBFC00004, 0xBFC00008, 0xBFC0000C on consecutive cycles -> 0x22222222, 0x33333333, 0x44444444; Stall_2IF=0; Mem_req never asserted.
- Conflict: 0xBFC00400 (same index, different tag) -> miss, refill, line replaced; a later 0xBFC00000 misses again.
- Redirect mid-fill: address changes to 0xBFC00020 during FILL -> fill for 0xBFC00000 completes, then a new REQ with Mem_addr=0xBFC00020.
- Delayed grant / gapped beats: Mem_gnt after 3 cycles, Mem_valid toggling 1-0-1-0 -> correct word order; stall extends exactly by the gaps.
- Invalidate during FILL and reset during FILL -> line not valid afterwards; next access to the same address misses; after reset, Mem_req=0 and Stall_2IF=1 while RESET=0.
